uart_tx_fifo: RTL

//  Byte buffer and launch sequencer directly upstream of uart_tx. Accepts bytes from a

---
 rtl/uart_tx_fifo.sv | 125 ++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO and launch sequencer feeding uart_tx over its start/data_in/busy handshake.
// Optional sticky overflow flag is enabled by defining UART_TX_FIFO_OVF_EN.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy,
  output logic              overflow,
  input  logic              ovf_clr
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                tx_start_q, tx_start_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                overflow_q, overflow_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                push;
  logic                pop;

  assign full     = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign overflow = overflow_q;

  // A full FIFO rejects writes even when the head is popped on the same edge.
  assign push = wr_en && !full;

  always_comb begin
    state_d    = state_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty && !tx_busy) begin
          tx_data_d  = mem_q[rd_ptr_q];
          tx_start_d = 1'b1;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (tx_busy) begin
          tx_start_d = 1'b0;
          pop        = 1'b1;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!tx_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        tx_start_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + ADDR_W'(push);
    rd_ptr_d = rd_ptr_q + ADDR_W'(pop);
    count_d  = count_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
  end

`ifdef UART_TX_FIFO_OVF_EN
  always_comb begin
    overflow_d = (overflow_q && !ovf_clr) || (wr_en && full);
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  always_comb begin
    overflow_d = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
